psum_ofifo: RTL and testbench

Output collection stage directly downstream of the MAC array. It captures each column's partial sum when that column asserts its write strobe, with one independent FIFO lane per column because columns finish skewed by one cycle each. It presents a complete row (one psum per column) to the consumer only when every lane holds data, and pops all lanes together on read.

---
 rtl/psum_ofifo_pkg.sv | 17 +
 rtl/psum_lane_fifo.sv | 56 +++++
 rtl/psum_ofifo.sv | 82 ++++++++
 tb/tb_psum_ofifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/psum_ofifo_pkg.sv
// rtl/psum_ofifo_pkg.sv - shared widths and types for the psum output FIFO
// Purpose: width constants, pointer width and psum type shared by psum_ofifo,
//          psum_lane_fifo and their testbench.
// Ports:   none (package).
package psum_ofifo_pkg;

  localparam int BW          = 8;
  localparam int BW_PSUM     = 2 * BW + 6;
  localparam int COL         = 8;
  localparam int OFIFO_DEPTH = 64;

  // One extra MSB over the address bits separates full from empty.
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH) + 1;

  typedef logic signed [BW_PSUM-1:0] psum_t;

endpackage

// File: rtl/psum_lane_fifo.sv
// rtl/psum_lane_fifo.sv - single-lane circular FIFO with external pop
// Purpose: one column's psum queue. Show-ahead head, pop driven by the top
//          level so that all lanes advance together.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   wr_en, wr_data      push request and data
//   pop                 accepted row read (only asserted when not empty)
//   empty, full         registered-pointer flags
//   head                storage word at the read pointer
module psum_lane_fifo #(
  parameter int width = 22,
  parameter int depth = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [width-1:0] head
);

  localparam int aw = $clog2(depth);
  localparam int pw = aw + 1;

  logic [pw-1:0]    wptr;
  logic [pw-1:0]    rptr;
  logic [width-1:0] mem [depth];
  logic             wr_acc;

  assign empty = (wptr == rptr);
  assign full  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);

  // A pop in the same cycle frees the slot the write lands in, so a full
  // lane still accepts the write.
  assign wr_acc = wr_en && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + pw'(1);
      if (pop)    rptr <= rptr + pw'(1);
    end
  end

  // Storage is not reset; its contents are masked by empty at the top.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[aw-1:0]] <= wr_data;
  end

  assign head = mem[rptr[aw-1:0]];

endmodule

// File: rtl/psum_ofifo.sv
// rtl/psum_ofifo.sv - per-column psum collection FIFO with row-aligned pop
// Purpose: captures skewed column psums into one lane FIFO per column and
//          presents a full row once every lane holds data; pops all lanes
//          together. Optional macro PSUM_OFIFO_RELU_EN clamps negative
//          output lanes to zero (storage stays raw).
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   in, wr       packed column psums (lane k at [bw_psum*k +: bw_psum]), per-lane write
//   rd           pop one row
//   out          head row, zero when o_valid is low
//   o_valid      every lane non-empty
//   o_full       at least one lane full; o_ready = ~o_full
//   overflow     sticky, a write was dropped
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw_psum = BW_PSUM,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);

  logic [col-1:0]     lane_empty;
  logic [col-1:0]     lane_full;
  logic [bw_psum-1:0] lane_head [col];
  logic               rd_acc;
  logic               drop;

  for (genvar k = 0; k < col; k++) begin : g_lane
    psum_lane_fifo #(
      .width (bw_psum),
      .depth (depth)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr[k]),
      .wr_data (in[bw_psum*k +: bw_psum]),
      .pop     (rd_acc),
      .empty   (lane_empty[k]),
      .full    (lane_full[k]),
      .head    (lane_head[k])
    );
  end

  assign o_valid = &(~lane_empty);
  assign o_full  = |lane_full;
  assign o_ready = ~o_full;
  assign rd_acc  = rd && o_valid;

  // Same acceptance rule as inside each lane: full lanes drop unless a row
  // is popped this cycle.
  assign drop = (|(wr & lane_full)) && !rd_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  always_comb begin
    out = '0;
    if (o_valid) begin
      for (int k = 0; k < col; k++) begin
`ifdef PSUM_OFIFO_RELU_EN
        out[bw_psum*k +: bw_psum] = lane_head[k][bw_psum-1] ? '0 : lane_head[k];
`else
        out[bw_psum*k +: bw_psum] = lane_head[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// tb/tb_psum_ofifo.sv - self-checking testbench for psum_ofifo
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  localparam int W = COL * BW_PSUM;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in_d;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out_d;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
  logic           overflow;

  int total = 0;
  int bad   = 0;

  logic [BW_PSUM-1:0] mq [COL][$];
  logic               m_ovf;

  psum_ofifo dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_d),
    .wr       (wr),
    .rd       (rd),
    .out      (out_d),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_ready  (o_ready),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_valid();
    for (int k = 0; k < COL; k++) if (mq[k].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all(input string tag);
    logic [W-1:0]       e_out;
    logic               e_full;
    logic [BW_PSUM-1:0] h;
    e_out  = '0;
    e_full = 1'b0;
    for (int k = 0; k < COL; k++) if (mq[k].size() == OFIFO_DEPTH) e_full = 1'b1;
    if (m_valid()) begin
      for (int k = 0; k < COL; k++) begin
        h = mq[k][0];
`ifdef PSUM_OFIFO_RELU_EN
        if (h[BW_PSUM-1]) h = '0;
`endif
        e_out[BW_PSUM*k +: BW_PSUM] = h;
      end
    end
    chk({tag, ".out"},      out_d,             e_out);
    chk({tag, ".o_valid"},  W'(o_valid),       W'(m_valid()));
    chk({tag, ".o_full"},   W'(o_full),        W'(e_full));
    chk({tag, ".o_ready"},  W'(o_ready),       W'(!e_full));
    chk({tag, ".overflow"}, W'(overflow),      W'(m_ovf));
  endtask

  // Drive one cycle, update the scoreboard with the expected effect, then
  // compare after the edge.
  task automatic cyc(input string tag, input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    logic racc;
    wr   = w;
    in_d = d;
    rd   = r;
    racc = r && m_valid();
    for (int k = 0; k < COL; k++) begin
      if (w[k]) begin
        if (mq[k].size() < OFIFO_DEPTH || racc) mq[k].push_back(d[BW_PSUM*k +: BW_PSUM]);
        else m_ovf = 1'b1;
      end
    end
    if (racc) for (int k = 0; k < COL; k++) void'(mq[k].pop_front());
    @(posedge clk);
    #2;
    wr = '0;
    rd = 1'b0;
    check_all(tag);
  endtask

  // Asynchronous reset between edges, checked before any clock edge.
  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    for (int k = 0; k < COL; k++) mq[k].delete();
    m_ovf = 1'b0;
    #1 check_all(tag);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  function automatic logic [W-1:0] row_of(input int base);
    logic [W-1:0] r;
    for (int k = 0; k < COL; k++) r[BW_PSUM*k +: BW_PSUM] = BW_PSUM'(base * 16 + k);
    return r;
  endfunction

  initial begin
    logic [W-1:0]       exp_row;
    logic [BW_PSUM-1:0] m5;
    logic [BW_PSUM-1:0] relu_m5;

    reset = 1'b0;
    wr    = '0;
    rd    = 1'b0;
    in_d  = '0;
    m_ovf = 1'b0;

    // reset state
    #3 check_all("reset");
    @(posedge clk);
    #2 reset = 1'b1;

    // skewed write, lane k gets k+1
    for (int k = 0; k < COL; k++) begin
      in_d = '0;
      in_d[BW_PSUM*k +: BW_PSUM] = BW_PSUM'(k + 1);
      cyc("skew", COL'(1) << k, in_d, 1'b0);
      if (k < COL - 1) chk("skew.early_valid", W'(o_valid), W'(0));
    end
    exp_row = '0;
    for (int k = 0; k < COL; k++) exp_row[BW_PSUM*k +: BW_PSUM] = BW_PSUM'(k + 1);
    chk("skew.row", out_d, exp_row);
    cyc("skew.pop", '0, '0, 1'b1);

    // fill to full, then one dropped row
    for (int r = 0; r < OFIFO_DEPTH; r++) cyc("fill", '1, row_of(r), 1'b0);
    chk("fill.o_full", W'(o_full), W'(1));
    chk("fill.o_ready", W'(o_ready), W'(0));
    cyc("drop", '1, row_of(999), 1'b0);
    chk("drop.overflow", W'(overflow), W'(1));
    chk("drop.head", out_d, row_of(0));

    // drain all but 10 rows, then reset mid-stream
    for (int r = 0; r < OFIFO_DEPTH - 10; r++) cyc("drain", '0, '0, 1'b1);
    chk("drain.head", out_d, row_of(OFIFO_DEPTH - 10));
    async_reset("midreset");
    chk("midreset.out", out_d, '0);

    // full lanes with simultaneous pop and lane 0 write
    for (int r = 0; r < OFIFO_DEPTH; r++) cyc("fill2", '1, row_of(r + 100), 1'b0);
    cyc("rdwr", 8'h01, row_of(500), 1'b1);
    chk("rdwr.overflow", W'(overflow), W'(0));
    chk("rdwr.o_full", W'(o_full), W'(1));
    for (int r = 0; r < OFIFO_DEPTH - 1; r++) cyc("drain2", '0, '0, 1'b1);
    chk("drain2.valid", W'(o_valid), W'(0));
    cyc("refill", 8'hFE, row_of(600), 1'b0);
    exp_row = row_of(600);
    exp_row[BW_PSUM-1:0] = BW_PSUM'(500 * 16);
    chk("refill.lane0", out_d, exp_row);
    cyc("refill.pop", '0, '0, 1'b1);

    // rd while lane 3 empty is ignored
    cyc("l3.wr", 8'hF7, row_of(20), 1'b0);
    cyc("l3.rd", '0, '0, 1'b1);
    chk("l3.out_zero", out_d, '0);
    cyc("l3.wr2", 8'hF7, row_of(21), 1'b0);
    cyc("l3.fill", 8'h08, row_of(20), 1'b0);
    chk("l3.row0", out_d, row_of(20));
    cyc("l3.fill2", 8'h08, row_of(21), 1'b1);
    chk("l3.row1", out_d, row_of(21));
    cyc("l3.pop", '0, '0, 1'b1);

    // negative psum, ReLU build clamps to zero
    m5 = BW_PSUM'(-5);
`ifdef PSUM_OFIFO_RELU_EN
    relu_m5 = '0;
`else
    relu_m5 = m5;
`endif
    cyc("neg", '1, {COL{m5}}, 1'b0);
    chk("neg.lane0", W'(out_d[BW_PSUM-1:0]), W'(relu_m5));
    chk("neg.lane7", W'(out_d[W-1 -: BW_PSUM]), W'(relu_m5));
    cyc("neg.pop", '0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
